// File: rtl/key_event_unit_pkg.sv
// Shared types and constants for the key event front end.
package key_evt_pkg;
  typedef enum logic [1:0] {REL, HELD, LONG} key_state_t;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/key_event_unit_if.sv
// Key pins in, debounced level and event pulses out; the unit is the slave side.
interface key_event_unit_if #(parameter int N_KEYS = 4) ();
  logic [N_KEYS-1:0] i_key_n;
  logic [N_KEYS-1:0] i_repeat_en;
  logic [N_KEYS-1:0] o_level;
  logic [N_KEYS-1:0] o_press;
  logic [N_KEYS-1:0] o_release;
  logic [N_KEYS-1:0] o_long;
  logic [N_KEYS-1:0] o_repeat;
  logic              o_any_press;

  modport slave  (input  i_key_n, i_repeat_en,
                  output o_level, o_press, o_release, o_long, o_repeat, o_any_press);
  modport master (output i_key_n, i_repeat_en,
                  input  o_level, o_press, o_release, o_long, o_repeat, o_any_press);
endinterface

// File: rtl/key_event_unit_chan.sv
// One key channel: pin synchroniser, debounce counter and press/hold/repeat FSM.
module key_event_chan
  import key_evt_pkg::*;
#(
  parameter int DEB_CYCLES    = 120000,
  parameter int LONG_CYCLES   = 12000000,
  parameter int REPEAT_CYCLES = 3000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat,
  output logic o_press_d
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CYCLES - 1);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic [DW-1:0]         deb_cnt;
  logic [HW-1:0]         hold_cnt;
  logic [RW-1:0]         rep_cnt;
  key_state_t            state;
  logic                  differs, deb_fire, acc_press, acc_rel;

  assign differs   = (~sync_q[SYNC_DEPTH-1]) != o_level;
  assign deb_fire  = differs && (deb_cnt == DEB_MAX);
  assign acc_press = deb_fire & ~o_level;
  assign acc_rel   = deb_fire &  o_level;
  assign o_press_d = acc_press;

  // Synchroniser resets to released so a key held through reset re-debounces.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_DEPTH-2:0], i_key_n};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_level <= 1'b0;
      deb_cnt <= '0;
    end else if (!differs) begin
      deb_cnt <= '0;
    end else if (deb_fire) begin
      o_level <= ~o_level;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Release is checked first so it suppresses a coincident long/repeat pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= REL;
      hold_cnt  <= '0;
      rep_cnt   <= '0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;
      case (state)
        REL: if (acc_press) begin
          state    <= HELD;
          o_press  <= 1'b1;
          hold_cnt <= '0;
        end
        HELD: if (acc_rel) begin
          state     <= REL;
          o_release <= 1'b1;
          hold_cnt  <= '0;
          rep_cnt   <= '0;
        end else if (hold_cnt == HOLD_MAX) begin
          state   <= LONG;
          o_long  <= 1'b1;
          rep_cnt <= '0;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
        LONG: if (acc_rel) begin
          state     <= REL;
          o_release <= 1'b1;
          hold_cnt  <= '0;
          rep_cnt   <= '0;
        end else if (rep_cnt == REP_MAX) begin
          rep_cnt  <= '0;
          o_repeat <= i_repeat_en;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
        default: state <= REL;
      endcase
    end
  end
endmodule

// File: rtl/key_event_unit.sv
// N independent key channels; top concatenates per-channel outputs and registers any-press.
module key_event_unit #(
  parameter int N_KEYS        = 4,
  parameter int DEB_CYCLES    = 120000,
  parameter int LONG_CYCLES   = 12000000,
  parameter int REPEAT_CYCLES = 3000000
) (
  input logic               i_clk,
  input logic               i_rst_n,
  key_event_unit_if.slave   kbus
);
  logic [N_KEYS-1:0] level, press, release_p, long_p, repeat_p, press_d;
  logic              any_q;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_chan
    key_event_chan #(
      .DEB_CYCLES    (DEB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_chan (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_key_n     (kbus.i_key_n[k]),
      .i_repeat_en (kbus.i_repeat_en[k]),
      .o_level     (level[k]),
      .o_press     (press[k]),
      .o_release   (release_p[k]),
      .o_long      (long_p[k]),
      .o_repeat    (repeat_p[k]),
      .o_press_d   (press_d[k])
    );
  end

  // Registered from the channels' next-cycle press so it lines up with o_press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) any_q <= 1'b0;
    else          any_q <= |press_d;
  end

  assign kbus.o_level     = level;
  assign kbus.o_press     = press;
  assign kbus.o_release   = release_p;
  assign kbus.o_long      = long_p;
  assign kbus.o_repeat    = repeat_p;
  assign kbus.o_any_press = any_q;
endmodule

// File: doc/key_event_unit.md
# key_event_unit

Parametrised N-channel push-button front end that replaces the single-key debouncer instances at board top level. Each channel synchronises an active-low raw key, debounces it, and emits one-cycle press, release, long-press and auto-repeat pulses. It sits between the board KEY pins and the audio controller's command inputs, in the 12 MHz audio clock domain.

## Interface
- N_KEYS, 4, number of independent key channels (1..16)
- DEB_CYCLES, 120000, consecutive cycles a new level must persist before it is accepted (≥1)
- LONG_CYCLES, 12000000, pressed-hold cycles before o_long fires (> DEB_CYCLES)
- REPEAT_CYCLES, 3000000, period of o_repeat pulses after o_long (≥1)

- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_key_n  in  N_KEYS  raw keys, active-low, asynchronous to i_clk
- i_repeat_en  in  N_KEYS  per-channel auto-repeat enable, sampled every cycle
- o_level  out  N_KEYS  debounced level, 1 = pressed
- o_press  out  N_KEYS  one-cycle pulse on accepted press
- o_release  out  N_KEYS  one-cycle pulse on accepted release
- o_long  out  N_KEYS  one-cycle pulse when hold reaches LONG_CYCLES
- o_repeat  out  N_KEYS  one-cycle pulse every REPEAT_CYCLES after o_long
- o_any_press  out  1  OR of o_press, registered same cycle as o_press

## Operation
- Per channel: 2-FF synchroniser (reset value 1 = released) → debounce counter → hold FSM.
- Debounce: counter increments while synchronised level ≠ o_level, clears to 0 on any cycle it equals o_level. When counter = DEB_CYCLES−1 and still differing, o_level toggles, counter clears. Glitches shorter than DEB_CYCLES produce no event.
- Hold FSM states: REL, HELD, LONG.
  - REL → HELD on accepted press; o_press=1, hold counter := 0.
  - HELD: hold counter increments; at LONG_CYCLES−1 → LONG, o_long=1, repeat counter := 0.
  - LONG: repeat counter increments; at REPEAT_CYCLES−1 wraps to 0 and o_repeat=1 iff i_repeat_en[k]=1 that cycle; otherwise counter still wraps silently.
  - HELD or LONG → REL on accepted release; o_release=1, counters clear.
- Accepted release on the same cycle as the long or repeat threshold: release wins, no o_long/o_repeat.
- Counter widths: $clog2(param+1); hold counter never exceeds LONG_CYCLES−1 (no wrap in HELD).
- Channels fully independent; simultaneous events on different channels all reported same cycle.

## Timing
- Reset: every output 0; FSM REL; all counters 0; synchronisers 1. Reset mid-press: after deassert, key still held is seen as a new press after 2+DEB_CYCLES cycles.
- Press latency: o_press high in cycle 2+DEB_CYCLES after the first edge sampling the new pin level; o_level rises the same cycle.
- o_long exactly LONG_CYCLES cycles after o_press; first o_repeat REPEAT_CYCLES cycles after o_long, then every REPEAT_CYCLES.
- All outputs registered; pulses exactly one cycle wide.

## Structure
- Package key_evt_pkg: typedef enum logic [1:0] {REL, HELD, LONG} key_state_t; localparam for synchroniser depth (2).
- Sub-module key_event_chan (one channel, same parameters) instantiated N_KEYS times via generate; top only concatenates outputs and forms o_any_press.

## Test plan
Bench parameters: N_KEYS=4, DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5.
- Reset held, keys low → all outputs 0; release reset with key0 low → o_press[0] at cycle 6 after release.
- Key1 low 3 cycles then high (glitch) → no o_press[1], o_level[1] stays 0.
- Key2 press held 40 cycles, i_repeat_en[2]=1 → o_press, o_long 20 cycles later, o_repeat at +5,+10,+15; o_release 6 cycles after pin returns high.
- Same as above with i_repeat_en[2]=0 → o_long fires, no o_repeat.
- Key3 released so accepted release lands on hold count 19 → o_release only, no o_long.
- Keys 0 and 3 pressed same cycle → both o_press bits high same cycle, o_any_press=1 for exactly one cycle; i_rst_n pulsed low mid-hold → outputs 0 asynchronously.
